accum_seq: RTL and testbench

ACCUM_SEQ -- requirements
Module: accum_seq

---
 rtl/accum_seq.sv | 139 +++++++++++++
 tb/tb_accum_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_seq.sv
// Sequencer in front of a pipelined FP32 accumulator. It feeds the elements of
// a data set into the accumulator, drains the pipeline for ACC_LAT cycles after
// the last element, then holds the captured sum and element count until the
// consumer takes them.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for the first element of a new set
// ACCUM | set in progress, waiting for further elements
// DRAIN | last element accepted, flushing ACC_LAT cycles through the pipe
// HOLD  | result captured, waiting for out_ready
module accum_seq #(
    parameter int ACC_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] acc_x,
    output logic        acc_start,
    output logic        acc_en,
    output logic        acc_clr,
    input  logic [31:0] acc_r,
    output logic [31:0] out_data,
    output logic [15:0] out_count,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [4:0] DRAIN_LAST = 5'(ACC_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  drain_cnt;
    logic [15:0] elem_cnt;
    logic        fire;
    logic        drain_done;

    // Handshake qualification: reset and flush both block acceptance.
    always_comb begin
        in_ready   = ((state == IDLE) || (state == ACCUM)) && !flush && !rst;
        fire       = in_valid && in_ready;
        drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
        acc_clr    = rst || flush;
    end

    // Next-state and accumulator-side outputs; rst/flush override everything.
    always_comb begin
        state_nxt = state;
        acc_x     = 32'h0000_0000;
        acc_en    = 1'b0;
        acc_start = 1'b0;
        if (fire) begin
            acc_x  = in_data;
            acc_en = 1'b1;
        end
        case (state)
            IDLE: begin
                if (fire) begin
                    acc_start = 1'b1;
                    state_nxt = in_last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (fire && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                acc_en = 1'b1;
                if (drain_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst || flush) begin
            acc_en    = 1'b0;
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain counter, element counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            elem_cnt  <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            drain_cnt <= '0;
            elem_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            // Held at zero outside DRAIN so every DRAIN visit starts from zero.
            drain_cnt <= (state == DRAIN) ? drain_cnt + 5'd1 : 5'd0;
            if (fire) begin
                if (state == IDLE) begin
                    elem_cnt <= 16'd1;
                end else if (elem_cnt != 16'hFFFF) begin
                    elem_cnt <= elem_cnt + 16'd1;
                end
            end
            if (drain_done) begin
                out_data  <= acc_r;
                out_count <= elem_cnt;
                out_valid <= 1'b1;
            end else if ((state == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_seq.sv
// Bench for accum_seq: a behavioural pipelined accumulator (exact for small
// integer-valued floats), table-driven sets, directed corner sequences and a
// randomized phase checked against a queue of expected {sum, count} results.
module tb_accum_seq;

    localparam int LAT = 5;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] acc_x;
    logic        acc_start;
    logic        acc_en;
    logic        acc_clr;
    logic [31:0] acc_r;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        out_valid;
    logic        out_ready;

    logic        rdy_req;
    logic        rnd_rdy;
    logic        rand_rdy;
    logic        mon_en;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] d;
        logic [15:0] c;
    } res_t;
    res_t exp_q[$];

    accum_seq #(.ACC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .acc_x(acc_x), .acc_start(acc_start),
        .acc_en(acc_en), .acc_clr(acc_clr), .acc_r(acc_r),
        .out_data(out_data), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign out_ready = rand_rdy ? rnd_rdy : rdy_req;

    function automatic int unsigned f2i(input logic [31:0] b);
        int e;
        logic [31:0] m;
        if (b[30:0] == 31'd0) return 0;
        e = int'(b[30:23]) - 127;
        m = {8'd0, 1'b1, b[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic logic [31:0] i2f(input int unsigned n);
        int p;
        logic [31:0] t;
        if (n == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (n[i]) p = i;
        t = n << (23 - p);
        return {1'b0, 8'(p + 127), t[22:0]};
    endfunction

    // Accumulator model: running sum entering a LAT-deep pipe that only moves when enabled.
    logic [31:0] pipe [LAT];
    int unsigned acc_sum;
    assign acc_r = pipe[LAT-1];

    always @(posedge clk) begin
        int unsigned s;
        if (acc_clr) begin
            acc_sum = 0;
            for (int i = 0; i < LAT; i++) pipe[i] <= 32'd0;
        end else if (acc_en) begin
            s = acc_start ? f2i(acc_x) : acc_sum + f2i(acc_x);
            acc_sum = s;
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= i2f(s);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Random out_ready source for the randomized phase.
    always begin
        @(negedge clk);
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    // Result monitor for the randomized phase.
    logic        hold_chk = 1'b0;
    logic [31:0] prev_d;
    logic [15:0] prev_c;
    always begin
        res_t r;
        @(negedge clk);
        #3;
        if (mon_en) begin
            if (hold_chk) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_d);
                check("hold_count", out_count, prev_c);
            end
            if (out_valid) check("hold_in_ready", in_ready, 1'b0);
            if (out_valid && out_ready && !rst && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", out_valid, 1'b0);
                end else begin
                    r = exp_q.pop_front();
                    check("rand_data", out_data, r.d);
                    check("rand_count", out_count, r.c);
                end
            end
            hold_chk = out_valid && !out_ready && !rst && !flush;
            prev_d   = out_data;
            prev_c   = out_count;
        end else begin
            hold_chk = 1'b0;
        end
    end

    // Offer one element (called at a falling edge), returns acc_start seen on the fire cycle.
    task automatic send_elem(input logic [31:0] d, input logic last, output logic st);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        st = acc_start;
        check("fire_acc_en", acc_en, 1'b1);
        check("fire_acc_x", acc_x, d);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
    endtask

    // Wait (from a falling edge) for out_valid; ends at falling edge + 1.
    task automatic wait_valid(output int n);
        n = 0;
        #1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic take_result();
        rdy_req = 1'b1;
        @(negedge clk);
        rdy_req = 1'b0;
        #1;
        check("take_valid_low", out_valid, 1'b0);
        check("take_in_ready", in_ready, 1'b1);
        @(negedge clk);
    endtask

    typedef struct {
        int          n;
        logic [31:0] v [4];
        int          gap;
        logic [31:0] exp_d;
        logic [15:0] exp_c;
    } vec_t;
    vec_t tbl [5];

    task automatic set_vec(input int idx, input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input int gap,
                           input logic [31:0] ed, input logic [15:0] ec);
        tbl[idx].n = n;
        tbl[idx].v[0] = a;
        tbl[idx].v[1] = b;
        tbl[idx].v[2] = c;
        tbl[idx].v[3] = d;
        tbl[idx].gap = gap;
        tbl[idx].exp_d = ed;
        tbl[idx].exp_c = ec;
    endtask

    initial begin
        logic st;
        int   n;
        logic drain_bad;
        logic [31:0] held_d;

        rst = 1'b1; flush = 1'b0; in_data = 32'd0; in_valid = 1'b0; in_last = 1'b0;
        rdy_req = 1'b0; rand_rdy = 1'b0; mon_en = 1'b0;

        set_vec(0, 1, 32'h40A00000, 0, 0, 0, 0, 32'h40A00000, 16'd1);
        set_vec(1, 3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 2, 32'h40C00000, 16'd3);
        set_vec(2, 4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0, 32'h41200000, 16'd4);
        set_vec(3, 2, 32'h41000000, 32'h41800000, 0, 0, 1, 32'h41C00000, 16'd2);
        set_vec(4, 1, 32'h3F800000, 0, 0, 0, 0, 32'h3F800000, 16'd1);

        // Reset behaviour, with an element offered during reset.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_acc_en", acc_en, 1'b0);
        check("rst_acc_clr", acc_clr, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_count", out_count, 16'd0);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_acc_clr", acc_clr, 1'b0);
        @(negedge clk);

        // Back-to-back three-element set with latency and acc_start checks.
        send_elem(32'h3F800000, 1'b0, st); check("b2b_start0", st, 1'b1);
        send_elem(32'h40000000, 1'b0, st); check("b2b_start1", st, 1'b0);
        send_elem(32'h40400000, 1'b1, st); check("b2b_start2", st, 1'b0);
        n = 0;
        drain_bad = 1'b0;
        #1;
        while (!out_valid && n < 20) begin
            if (!acc_en || acc_x != 32'd0) drain_bad = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        check("b2b_latency", n, 5);
        check("b2b_drain_en", drain_bad, 1'b0);
        check("b2b_data", out_data, 32'h40C00000);
        check("b2b_count", out_count, 16'd3);
        take_result();

        // Table-driven sets.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                send_elem(tbl[t].v[i], i == tbl[t].n - 1, st);
                check($sformatf("tbl%0d_start%0d", t, i), st, i == 0);
                if (i != tbl[t].n - 1) begin
                    for (int g = 0; g < tbl[t].gap; g++) begin
                        #1;
                        check($sformatf("tbl%0d_gap_en", t), acc_en, 1'b0);
                        check($sformatf("tbl%0d_gap_x", t), acc_x, 32'd0);
                        @(negedge clk);
                    end
                end
            end
            wait_valid(n);
            check($sformatf("tbl%0d_data", t), out_data, tbl[t].exp_d);
            check($sformatf("tbl%0d_count", t), out_count, tbl[t].exp_c);
            take_result();
        end

        // Consumer stalls for 10 cycles in HOLD.
        send_elem(32'h40000000, 1'b0, st);
        send_elem(32'h40800000, 1'b1, st);
        wait_valid(n);
        held_d = out_data;
        check("stall_data", held_d, 32'h40C00000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", out_valid, 1'b1);
            check("stall_data_stable", out_data, held_d);
            check("stall_in_ready", in_ready, 1'b0);
        end
        take_result();

        // Flush on the third DRAIN cycle.
        send_elem(32'h40000000, 1'b0, st);
        send_elem(32'h40000000, 1'b1, st);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_acc_clr", acc_clr, 1'b1);
        check("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("flush_no_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        send_elem(32'h3F800000, 1'b1, st);
        check("flush_next_start", st, 1'b1);
        wait_valid(n);
        check("flush_next_data", out_data, 32'h3F800000);
        check("flush_next_count", out_count, 16'd1);
        take_result();

        // Reset in the middle of a set.
        send_elem(32'h3F800000, 1'b0, st);
        send_elem(32'h40000000, 1'b0, st);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h40400000;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_acc_en", acc_en, 1'b0);
        check("mid_rst_acc_clr", acc_clr, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_count", out_count, 16'd0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        send_elem(32'h40000000, 1'b1, st);
        check("mid_rst_start", st, 1'b1);
        wait_valid(n);
        check("mid_rst_data", out_data, 32'h40000000);
        check("mid_rst_count", out_count, 16'd1);
        take_result();

        // Randomized sets with random gaps and random consumer backpressure.
        rand_rdy = 1'b1;
        mon_en = 1'b1;
        for (int s = 0; s < 25; s++) begin
            int unsigned len;
            int unsigned sum;
            int unsigned v;
            res_t r;
            len = $urandom_range(1, 6);
            sum = 0;
            for (int i = 0; i < int'(len); i++) begin
                v = $urandom_range(1, 50);
                sum += v;
                send_elem(i2f(v), i == int'(len) - 1, st);
                check("rand_start", st, i == 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            r.d = i2f(sum);
            r.c = 16'(len);
            exp_q.push_back(r);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rand_drained", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
